// File: rtl/reservation_station_param_pkg.sv
// Shared definitions for the ALU reservation station: default widths, the null
// operand tag and the ALU opcode set.
package reservation_station_param_pkg;

    localparam int DEF_DEPTH   = 16;
    localparam int DEF_TAG_W   = 4;
    localparam int DEF_NUM_CDB = 2;
    localparam int DEF_WORD_W  = 32;
    localparam int DEF_OP_W    = 6;

    // Tag value meaning "operand already present"; it never matches a broadcast.
    localparam int NULL_TAG = 0;

    typedef enum logic [DEF_OP_W-1:0] {
        OP_NOP = 6'd0,
        OP_ADD = 6'd1,
        OP_SUB = 6'd2,
        OP_AND = 6'd3,
        OP_OR  = 6'd4,
        OP_XOR = 6'd5,
        OP_SLL = 6'd6,
        OP_SRL = 6'd7
    } alu_op_e;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/reservation_station_param_if.sv
// Dispatch, common-data-bus and issue signals of the reservation station.
// slave = the station itself, master = the surrounding pipeline.
interface reservation_station_param_if #(
    parameter int DEPTH   = reservation_station_param_pkg::DEF_DEPTH,
    parameter int TAG_W   = reservation_station_param_pkg::DEF_TAG_W,
    parameter int NUM_CDB = reservation_station_param_pkg::DEF_NUM_CDB,
    parameter int WORD_W  = reservation_station_param_pkg::DEF_WORD_W,
    parameter int OP_W    = reservation_station_param_pkg::DEF_OP_W
);
    import reservation_station_param_pkg::*;

    localparam int CNT_W = count_width(DEPTH);

    logic                        dis_valid_in;
    logic [OP_W-1:0]             dis_op_in;
    logic [WORD_W-1:0]           dis_imm_in;
    logic [WORD_W-1:0]           dis_pc_in;
    logic [TAG_W-1:0]            dis_dest_in;
    logic [WORD_W-1:0]           dis_Vj_in;
    logic [WORD_W-1:0]           dis_Vk_in;
    logic [TAG_W-1:0]            dis_Qj_in;
    logic [TAG_W-1:0]            dis_Qk_in;
    logic                        full_out;
    logic [CNT_W-1:0]            count_out;

    logic [NUM_CDB-1:0]          cdb_valid_in;
    logic [NUM_CDB*TAG_W-1:0]    cdb_tag_in;
    logic [NUM_CDB*WORD_W-1:0]   cdb_value_in;

    logic                        issue_valid_out;
    logic                        issue_ready_in;
    logic [OP_W-1:0]             issue_op_out;
    logic [WORD_W-1:0]           issue_imm_out;
    logic [WORD_W-1:0]           issue_pc_out;
    logic [WORD_W-1:0]           issue_lhs_out;
    logic [WORD_W-1:0]           issue_rhs_out;
    logic [TAG_W-1:0]            issue_dest_out;

    modport slave (
        input  dis_valid_in, dis_op_in, dis_imm_in, dis_pc_in, dis_dest_in,
               dis_Vj_in, dis_Vk_in, dis_Qj_in, dis_Qk_in,
               cdb_valid_in, cdb_tag_in, cdb_value_in, issue_ready_in,
        output full_out, count_out, issue_valid_out, issue_op_out, issue_imm_out,
               issue_pc_out, issue_lhs_out, issue_rhs_out, issue_dest_out
    );

    modport master (
        output dis_valid_in, dis_op_in, dis_imm_in, dis_pc_in, dis_dest_in,
               dis_Vj_in, dis_Vk_in, dis_Qj_in, dis_Qk_in,
               cdb_valid_in, cdb_tag_in, cdb_value_in, issue_ready_in,
        input  full_out, count_out, issue_valid_out, issue_op_out, issue_imm_out,
               issue_pc_out, issue_lhs_out, issue_rhs_out, issue_dest_out
    );

endinterface

// File: rtl/reservation_station_param_age_select.sv
// Oldest-ready picker: age[i][j]=1 means entry i was dispatched before entry j.
// An entry is granted when it is ready and no ready entry is older than it.
module rs_age_select #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0] ready,
    input  logic [DEPTH-1:0] age [DEPTH],
    output logic [DEPTH-1:0] grant,
    output logic             any_ready
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
        logic [DEPTH-1:0] older_ready;
        for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
            assign older_ready[gj] = ready[gj] & age[gj][gi];
        end
        assign grant[gi] = ready[gi] & ~(|older_ready);
    end

    assign any_ready = |ready;

endmodule

// File: rtl/reservation_station_param.sv
// Out-of-order ALU reservation station: CDB operand wakeup, dispatch bypass,
// oldest-ready issue through a valid/ready register, flush and back-pressure.
module reservation_station_param
    import reservation_station_param_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int NUM_CDB = DEF_NUM_CDB,
    parameter int WORD_W  = DEF_WORD_W,
    parameter int OP_W    = DEF_OP_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_in,
    reservation_station_param_if.slave  rs
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [TAG_W-1:0] NULL_T = TAG_W'(NULL_TAG);

    // Entry storage; contents are only meaningful while the busy bit is set.
    logic [OP_W-1:0]   op_mem   [DEPTH];
    logic [WORD_W-1:0] imm_mem  [DEPTH];
    logic [WORD_W-1:0] pc_mem   [DEPTH];
    logic [TAG_W-1:0]  dest_mem [DEPTH];
    logic [WORD_W-1:0] vj_mem   [DEPTH];
    logic [WORD_W-1:0] vk_mem   [DEPTH];
    logic [TAG_W-1:0]  qj_mem   [DEPTH];
    logic [TAG_W-1:0]  qk_mem   [DEPTH];

    logic [DEPTH-1:0]  busy_reg, busy_next;
    logic [DEPTH-1:0]  age_reg  [DEPTH];

    logic              issue_valid_reg;
    logic [OP_W-1:0]   issue_op_reg;
    logic [WORD_W-1:0] issue_imm_reg, issue_pc_reg, issue_lhs_reg, issue_rhs_reg;
    logic [TAG_W-1:0]  issue_dest_reg;

    logic [TAG_W-1:0]  cdb_tag [NUM_CDB];
    logic [WORD_W-1:0] cdb_val [NUM_CDB];

    logic [DEPTH-1:0]  ready_vec, grant;
    logic              any_ready;
    logic [IDX_W-1:0]  free_idx, sel_idx;
    logic [CNT_W-1:0]  busy_cnt;
    logic              full, dis_fire, issue_open, issue_take;

    logic [DEPTH-1:0]  wj_hit, wk_hit;
    logic [WORD_W-1:0] wj_val [DEPTH];
    logic [WORD_W-1:0] wk_val [DEPTH];
    logic              bj_hit, bk_hit;
    logic [WORD_W-1:0] bj_val, bk_val;

    for (genvar gi = 0; gi < NUM_CDB; gi++) begin : g_cdb
        assign cdb_tag[gi] = rs.cdb_tag_in[gi*TAG_W +: TAG_W];
        assign cdb_val[gi] = rs.cdb_value_in[gi*WORD_W +: WORD_W];
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
        assign ready_vec[gi] = busy_reg[gi] && (qj_mem[gi] == NULL_T) && (qk_mem[gi] == NULL_T);
    end

    rs_age_select #(.DEPTH(DEPTH)) u_age_select (
        .ready     (ready_vec),
        .age       (age_reg),
        .grant     (grant),
        .any_ready (any_ready)
    );

    // Snoop scans channels high to low so the lowest matching channel wins.
    always_comb begin
        wj_hit = '0;
        wk_hit = '0;
        bj_hit = 1'b0;
        bk_hit = 1'b0;
        bj_val = '0;
        bk_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wj_val[i] = '0;
            wk_val[i] = '0;
        end
        for (int c = NUM_CDB-1; c >= 0; c--) begin
            if (rs.cdb_valid_in[c] && cdb_tag[c] != NULL_T) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (qj_mem[i] == cdb_tag[c]) begin
                        wj_hit[i] = 1'b1;
                        wj_val[i] = cdb_val[c];
                    end
                    if (qk_mem[i] == cdb_tag[c]) begin
                        wk_hit[i] = 1'b1;
                        wk_val[i] = cdb_val[c];
                    end
                end
                if (rs.dis_Qj_in == cdb_tag[c]) begin
                    bj_hit = 1'b1;
                    bj_val = cdb_val[c];
                end
                if (rs.dis_Qk_in == cdb_tag[c]) begin
                    bk_hit = 1'b1;
                    bk_val = cdb_val[c];
                end
            end
        end
    end

    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        busy_cnt = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!busy_reg[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) sel_idx = IDX_W'(i);
            busy_cnt = busy_cnt + CNT_W'(busy_reg[i]);
        end
    end

    assign full       = (busy_cnt == CNT_W'(DEPTH));
    assign dis_fire   = rs.dis_valid_in && !full && !flush_in;
    assign issue_open = !issue_valid_reg || rs.issue_ready_in;
    assign issue_take = issue_open && any_ready && !flush_in;

    always_comb begin
        busy_next = busy_reg;
        if (issue_take) busy_next[sel_idx] = 1'b0;
        if (dis_fire)   busy_next[free_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg        <= '0;
            for (int i = 0; i < DEPTH; i++) age_reg[i] <= '0;
            issue_valid_reg <= 1'b0;
            issue_op_reg    <= OP_W'(OP_NOP);
            issue_imm_reg   <= '0;
            issue_pc_reg    <= '0;
            issue_lhs_reg   <= '0;
            issue_rhs_reg   <= '0;
            issue_dest_reg  <= '0;
        end else if (flush_in) begin
            busy_reg        <= '0;
            for (int i = 0; i < DEPTH; i++) age_reg[i] <= '0;
            issue_valid_reg <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            // New entry is younger than every currently busy entry.
            if (dis_fire) begin
                for (int j = 0; j < DEPTH; j++) age_reg[j][free_idx] <= busy_reg[j];
                age_reg[free_idx] <= '0;
            end
            if (issue_open) begin
                issue_valid_reg <= any_ready;
                if (any_ready) begin
                    issue_op_reg   <= op_mem[sel_idx];
                    issue_imm_reg  <= imm_mem[sel_idx];
                    issue_pc_reg   <= pc_mem[sel_idx];
                    issue_lhs_reg  <= vj_mem[sel_idx];
                    issue_rhs_reg  <= vk_mem[sel_idx];
                    issue_dest_reg <= dest_mem[sel_idx];
                end
            end
        end
    end

    // Payload storage needs no reset: busy bits gate every use of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wj_hit[i]) begin
                vj_mem[i] <= wj_val[i];
                qj_mem[i] <= NULL_T;
            end
            if (wk_hit[i]) begin
                vk_mem[i] <= wk_val[i];
                qk_mem[i] <= NULL_T;
            end
        end
        if (dis_fire) begin
            op_mem[free_idx]   <= rs.dis_op_in;
            imm_mem[free_idx]  <= rs.dis_imm_in;
            pc_mem[free_idx]   <= rs.dis_pc_in;
            dest_mem[free_idx] <= rs.dis_dest_in;
            vj_mem[free_idx]   <= bj_hit ? bj_val : rs.dis_Vj_in;
            vk_mem[free_idx]   <= bk_hit ? bk_val : rs.dis_Vk_in;
            qj_mem[free_idx]   <= bj_hit ? NULL_T : rs.dis_Qj_in;
            qk_mem[free_idx]   <= bk_hit ? NULL_T : rs.dis_Qk_in;
        end
    end

    assign rs.full_out        = full;
    assign rs.count_out       = busy_cnt;
    assign rs.issue_valid_out = issue_valid_reg;
    assign rs.issue_op_out    = issue_op_reg;
    assign rs.issue_imm_out   = issue_imm_reg;
    assign rs.issue_pc_out    = issue_pc_reg;
    assign rs.issue_lhs_out   = issue_lhs_reg;
    assign rs.issue_rhs_out   = issue_rhs_reg;
    assign rs.issue_dest_out  = issue_dest_reg;

endmodule
